// File: rtl/fe_capture_sequencer_pkg.sv
// fe_capture_sequencer_pkg
//   Shared encodings for the USB front-end capture path: the FIFO command
//   codes that tag each capture FIFO entry, and the capture sequencer states.
//   No ports; imported by the sequencer and its gap timer.
package fe_capture_sequencer_pkg;

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
    localparam logic [1:0] FE_FIFO_CMD_STAT = 2'b01;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

    // Width of the short-timestamp limit supplied by the register block.
    localparam int MAX_SHORT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/fe_capture_sequencer_gap_timer.sv
// fe_gap_timer
//   Cycle-gap timestamp counter for the capture sequencer. Counts cycles
//   since the last accepted event (saturating at all-ones), and classifies
//   the event presented this cycle as long (needs a full TIME entry) or short.
// Ports:
//   fe_clk, reset_i   clock and synchronous active-high reset
//   restart           capture is being armed: counter to 0, first-event flag set
//   running           capture in progress: counter advances
//   event_load        an event is accepted this cycle: counter loads 1
//   long_taken        a TIME entry is written this cycle: first-event flag clears
//   max_short         largest gap that fits a short time field
//   gap               current counter value (the gap of an event this cycle)
//   is_long           first event of the capture, or gap > max_short
module fe_gap_timer
    import fe_capture_sequencer_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH = 16
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic                             restart,
    input  logic                             running,
    input  logic                             event_load,
    input  logic                             long_taken,
    input  logic [MAX_SHORT_WIDTH-1:0]       max_short,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] gap,
    output logic                             is_long
);

    logic [pTIMESTAMP_FULL_WIDTH-1:0] gap_reg;
    logic                             first_reg;

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            gap_reg   <= '0;
            first_reg <= 1'b0;
        end else if (restart) begin
            gap_reg   <= '0;
            first_reg <= 1'b1;
        end else begin
            if (event_load) begin
                // The next cycle is already one cycle after this event.
                gap_reg <= pTIMESTAMP_FULL_WIDTH'(1);
            end else if (running && (gap_reg != '1)) begin
                gap_reg <= gap_reg + pTIMESTAMP_FULL_WIDTH'(1);
            end
            if (long_taken) begin
                first_reg <= 1'b0;
            end
        end
    end

    assign gap = gap_reg;
    // Compare at a common width so any counter width works against the 16-bit limit.
    assign is_long = first_reg || (32'(gap_reg) > 32'(max_short));

endmodule

// File: rtl/fe_capture_sequencer.sv
// fe_capture_sequencer
//   Write scheduler for the USB front-end capture FIFO. Each accepted event is
//   written one cycle after it is seen, carrying its command and its short gap.
//   When the gap does not fit a short field (or it is the first event of a
//   capture) a full-width TIME entry is written in the event's own cycle, and
//   the event's entry then carries time 0. Also sequences arm/stop/length
//   limit and flags FIFO overflow.
// Ports:
//   fe_clk, reset_i        clock and synchronous active-high reset
//   I_arm, I_stop          one-cycle pulses: start / abort a capture
//   I_capture_len          events to capture, 0 = unlimited
//   I_event, I_data_cmd    event strobe and its command (DATA or STAT)
//   I_max_short_timestamp  largest gap encodable in a short time field
//   I_fifo_full            capture FIFO full
//   O_fifo_wr/_command/_time  FIFO write request, command, time payload
//   O_capturing, O_done, O_overflow, O_event_count  status
module fe_capture_sequencer
    import fe_capture_sequencer_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pCAPTURE_LEN_WIDTH    = 24
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic                             I_arm,
    input  logic                             I_stop,
    input  logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len,
    input  logic                             I_event,
    input  logic [1:0]                       I_data_cmd,
    input  logic [MAX_SHORT_WIDTH-1:0]       I_max_short_timestamp,
    input  logic                             I_fifo_full,
    output logic                             O_fifo_wr,
    output logic [1:0]                       O_fifo_command,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
    output logic                             O_capturing,
    output logic                             O_done,
    output logic                             O_overflow,
    output logic [pCAPTURE_LEN_WIDTH-1:0]    O_event_count
);

    cap_state_t                       state_reg;
    logic                             pend_wr_reg;
    logic [1:0]                       pend_cmd_reg;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] pend_time_reg;
    logic [1:0]                       hold_cmd_reg;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] hold_time_reg;
    logic                             done_reg;
    logic                             overflow_reg;
    logic [pCAPTURE_LEN_WIDTH-1:0]    count_reg;

    logic                             capturing;
    logic                             arm_ok;
    logic                             pend_limit;
    logic                             candidate;
    logic                             time_wr;
    logic                             overflow_now;
    logic                             accept;
    logic                             leave;
    logic [pTIMESTAMP_FULL_WIDTH-1:0] gap;
    logic                             is_long;

    fe_gap_timer #(
        .pTIMESTAMP_FULL_WIDTH(pTIMESTAMP_FULL_WIDTH)
    ) u_gap_timer (
        .fe_clk     (fe_clk),
        .reset_i    (reset_i),
        .restart    (arm_ok),
        .running    (capturing),
        .event_load (accept),
        .long_taken (time_wr),
        .max_short  (I_max_short_timestamp),
        .gap        (gap),
        .is_long    (is_long)
    );

    assign capturing = (state_reg == ST_CAPTURE);
    assign arm_ok    = !capturing && I_arm;

    // The scheduled write this cycle is the one that reaches the length limit.
    assign pend_limit = pend_wr_reg && (I_capture_len != '0)
                        && ((count_reg + pCAPTURE_LEN_WIDTH'(1)) == I_capture_len);

    // An event is only considered if the block stays in CAPTURE for its own
    // write slot: not on stop, not alongside the final or an overflowing write.
    assign candidate = capturing && I_event && !I_stop && !reset_i
                       && !pend_limit && !(pend_wr_reg && I_fifo_full);

    // A long event implies the previous cycle had no event, so the slot is free.
    // The only exception is a zero short limit; then the event stays short.
    assign time_wr      = candidate && is_long && !pend_wr_reg;
    assign overflow_now = (time_wr || pend_wr_reg) && I_fifo_full;
    // A TIME entry hitting a full FIFO ends the capture, so its event is dropped.
    assign accept       = candidate && !(time_wr && I_fifo_full);
    assign leave        = capturing && (I_stop || pend_limit || overflow_now);

    assign O_fifo_wr      = time_wr || pend_wr_reg;
    assign O_fifo_command = time_wr ? FE_FIFO_CMD_TIME
                                    : (pend_wr_reg ? pend_cmd_reg : hold_cmd_reg);
    assign O_fifo_time    = time_wr ? gap
                                    : (pend_wr_reg ? pend_time_reg : hold_time_reg);
    assign O_capturing    = capturing;
    assign O_done         = done_reg;
    assign O_overflow     = overflow_reg;
    assign O_event_count  = count_reg;

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_reg     <= ST_IDLE;
            pend_wr_reg   <= 1'b0;
            pend_cmd_reg  <= '0;
            pend_time_reg <= '0;
            hold_cmd_reg  <= '0;
            hold_time_reg <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
        end else begin
            pend_wr_reg <= accept;
            if (accept) begin
                pend_cmd_reg  <= I_data_cmd;
                pend_time_reg <= time_wr ? '0 : gap;
            end
            // Remember the last presented entry so idle cycles hold it.
            if (O_fifo_wr) begin
                hold_cmd_reg  <= O_fifo_command;
                hold_time_reg <= O_fifo_time;
            end
            if (pend_wr_reg) begin
                count_reg <= count_reg + pCAPTURE_LEN_WIDTH'(1);
            end
            if (overflow_now) begin
                overflow_reg <= 1'b1;
            end
            case (state_reg)
                ST_CAPTURE: begin
                    if (leave) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    if (I_arm) begin
                        state_reg    <= ST_CAPTURE;
                        done_reg     <= 1'b0;
                        overflow_reg <= 1'b0;
                        count_reg    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fe_capture_sequencer.sv
module tb_fe_capture_sequencer;
    import fe_capture_sequencer_pkg::*;

    localparam int TW = 16;
    localparam int CW = 24;

    logic          fe_clk = 1'b0;
    logic          reset_i;
    logic          I_arm, I_stop, I_event, I_fifo_full;
    logic [CW-1:0] I_capture_len;
    logic [1:0]    I_data_cmd;
    logic [15:0]   I_max_short_timestamp;
    logic          O_fifo_wr;
    logic [1:0]    O_fifo_command;
    logic [TW-1:0] O_fifo_time;
    logic          O_capturing, O_done, O_overflow;
    logic [CW-1:0] O_event_count;

    fe_capture_sequencer #(
        .pTIMESTAMP_FULL_WIDTH(TW),
        .pCAPTURE_LEN_WIDTH(CW)
    ) dut (
        .fe_clk                (fe_clk),
        .reset_i               (reset_i),
        .I_arm                 (I_arm),
        .I_stop                (I_stop),
        .I_capture_len         (I_capture_len),
        .I_event               (I_event),
        .I_data_cmd            (I_data_cmd),
        .I_max_short_timestamp (I_max_short_timestamp),
        .I_fifo_full           (I_fifo_full),
        .O_fifo_wr             (O_fifo_wr),
        .O_fifo_command        (O_fifo_command),
        .O_fifo_time           (O_fifo_time),
        .O_capturing           (O_capturing),
        .O_done                (O_done),
        .O_overflow            (O_overflow),
        .O_event_count         (O_event_count)
    );

    always #5 fe_clk = ~fe_clk;

    int     vectors = 0;
    int     misc    = 0;
    longint cyc     = 0;

    // ---------------- directed table ----------------
    typedef struct {
        logic        arm, stop, ev;
        logic [1:0]  cmd;
        logic        full;
        logic        wr;
        logic [1:0]  ecmd;
        logic [15:0] etime;
        logic [23:0] ecnt;
        logic        cap, done, ovf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic a, input logic s, input logic e, input logic [1:0] c,
                                input logic f, input logic w, input logic [1:0] ec,
                                input logic [15:0] et, input logic [23:0] cnt,
                                input logic cp, input logic dn, input logic ov);
        vec_t v;
        v.arm = a; v.stop = s; v.ev = e; v.cmd = c; v.full = f;
        v.wr = w; v.ecmd = ec; v.etime = et; v.ecnt = cnt;
        v.cap = cp; v.done = dn; v.ovf = ov;
        return v;
    endfunction

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_CAP = 1, M_DONE = 2;
    typedef struct { longint due; logic [1:0] cmd; logic [15:0] t; } sched_t;
    typedef struct { logic [1:0] cmd; logic [15:0] t; } wr_t;

    int         m_mode;
    bit         m_first, m_done, m_ovf;
    longint     m_ref;
    int         m_count;
    logic [1:0] m_last_cmd;
    logic [15:0] m_last_time;
    sched_t     m_q[$];
    wr_t        wlog[$];

    logic        s_wr, s_cap, s_done, s_ovf;
    logic [1:0]  s_cmd;
    logic [15:0] s_time;
    logic [23:0] s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_mode = M_IDLE; m_first = 0; m_done = 0; m_ovf = 0;
        m_ref = 0; m_count = 0; m_last_cmd = 0; m_last_time = 0;
        m_q.delete();
    endfunction

    // One clock cycle: apply inputs, sample outputs late in the cycle, check
    // against the model, advance the model, then move past the next edge.
    task automatic step(input logic arm, input logic stop, input logic ev,
                        input logic [1:0] cmd, input logic full, input logic rst);
        bit pend, cap, plim, cand, lng, ovf_now, acc, ewr;
        logic [1:0] ecmd;
        logic [15:0] etime;
        longint g;
        I_arm = arm; I_stop = stop; I_event = ev; I_data_cmd = cmd;
        I_fifo_full = full; reset_i = rst;
        @(negedge fe_clk);
        s_wr = O_fifo_wr; s_cmd = O_fifo_command; s_time = O_fifo_time;
        s_cap = O_capturing; s_done = O_done; s_ovf = O_overflow; s_cnt = O_event_count;
        if (s_wr === 1'b1) wlog.push_back('{O_fifo_command, O_fifo_time});

        pend = (m_q.size() > 0) && (m_q[0].due == cyc);
        g = cyc - m_ref;
        if (g > 65535) g = 65535;
        cap  = (m_mode == M_CAP);
        plim = pend && (I_capture_len != 0) && ((m_count + 1) == int'(I_capture_len));
        cand = cap && ev && !stop && !rst && !plim && !(pend && full);
        lng  = cand && !pend && (m_first || (g > longint'(I_max_short_timestamp)));
        ewr  = lng || pend;
        ecmd  = lng ? FE_FIFO_CMD_TIME : (pend ? m_q[0].cmd : m_last_cmd);
        etime = lng ? 16'(g) : (pend ? m_q[0].t : m_last_time);

        chk("wr", 32'(s_wr), 32'(ewr));
        chk("command", 32'(s_cmd), 32'(ecmd));
        chk("time", 32'(s_time), 32'(etime));
        chk("capturing", 32'(s_cap), 32'(cap));
        chk("done", 32'(s_done), 32'(m_done));
        chk("overflow", 32'(s_ovf), 32'(m_ovf));
        chk("event_count", 32'(s_cnt), 32'(m_count));

        if (rst) begin
            model_clear();
        end else begin
            ovf_now = ewr && full;
            acc = cand && !(lng && full);
            if (ewr) begin
                m_last_cmd = ecmd;
                m_last_time = etime;
            end
            if (pend) begin
                m_count++;
                void'(m_q.pop_front());
            end
            if (lng) m_first = 0;
            if (acc) begin
                m_q.push_back('{cyc + 1, cmd, lng ? 16'd0 : 16'(g)});
                m_ref = cyc;
            end
            if (ovf_now) m_ovf = 1;
            if (cap) begin
                if (stop || plim || ovf_now) begin
                    m_mode = M_DONE;
                    m_done = 1;
                end
            end else if (arm) begin
                m_mode = M_CAP; m_done = 0; m_ovf = 0; m_count = 0;
                m_first = 1; m_ref = cyc + 1;
            end
        end
        cyc++;
        @(posedge fe_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [1:0] c, input logic [15:0] t);
        if (idx < wlog.size()) begin
            chk({name, "_cmd"}, 32'(wlog[idx].cmd), 32'(c));
            chk({name, "_time"}, 32'(wlog[idx].t), 32'(t));
        end else begin
            chk({name, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    task automatic hard_reset();
        I_arm = 0; I_stop = 0; I_event = 0; I_data_cmd = 0; I_fifo_full = 0;
        reset_i = 1;
        @(posedge fe_clk);
        #1;
        reset_i = 0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        misc++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

    initial begin
        int n_evw;
        bit burst;
        reset_i = 1; I_arm = 0; I_stop = 0; I_event = 0; I_data_cmd = 0;
        I_fifo_full = 0; I_capture_len = 0; I_max_short_timestamp = 16'd7;

        // ---- reset state ----
        repeat (3) @(posedge fe_clk);
        @(negedge fe_clk);
        chk("reset_wr", 32'(O_fifo_wr), 0);
        chk("reset_cmd", 32'(O_fifo_command), 0);
        chk("reset_time", 32'(O_fifo_time), 0);
        chk("reset_capturing", 32'(O_capturing), 0);
        chk("reset_done", 32'(O_done), 0);
        chk("reset_overflow", 32'(O_overflow), 0);
        chk("reset_count", 32'(O_event_count), 0);
        @(posedge fe_clk);
        #1;
        reset_i = 0;

        // ---- table-driven vectors: max_short=2, capture_len=3 ----
        tbl[0]  = mk(1,0,0,0,0, 0,0,0,0, 0,0,0);
        tbl[1]  = mk(0,0,0,0,0, 0,0,0,0, 1,0,0);
        tbl[2]  = mk(0,0,0,0,0, 0,0,0,0, 1,0,0);
        tbl[3]  = mk(0,0,1,0,0, 1,2,2,0, 1,0,0);
        tbl[4]  = mk(0,0,1,1,0, 1,0,0,0, 1,0,0);
        tbl[5]  = mk(0,0,0,0,0, 1,1,1,1, 1,0,0);
        tbl[6]  = mk(0,0,0,0,0, 0,1,1,2, 1,0,0);
        tbl[7]  = mk(0,0,0,0,0, 0,1,1,2, 1,0,0);
        tbl[8]  = mk(0,0,1,0,0, 1,2,4,2, 1,0,0);
        tbl[9]  = mk(0,0,1,1,0, 1,0,0,2, 1,0,0);
        tbl[10] = mk(0,0,1,0,0, 0,0,0,3, 0,1,0);
        tbl[11] = mk(1,0,0,0,0, 0,0,0,3, 0,1,0);
        tbl[12] = mk(0,0,1,0,1, 1,2,0,0, 1,0,0);
        tbl[13] = mk(0,0,0,0,0, 0,2,0,0, 0,1,1);
        tbl[14] = mk(1,0,0,0,0, 0,2,0,0, 0,1,1);
        tbl[15] = mk(0,0,0,0,0, 0,2,0,0, 1,0,0);
        tbl[16] = mk(0,1,1,0,0, 0,2,0,0, 1,0,0);
        tbl[17] = mk(0,0,0,0,0, 0,2,0,0, 0,1,0);
        I_max_short_timestamp = 16'd2;
        I_capture_len = 24'd3;
        for (int i = 0; i < 18; i++) begin
            I_arm = tbl[i].arm; I_stop = tbl[i].stop; I_event = tbl[i].ev;
            I_data_cmd = tbl[i].cmd; I_fifo_full = tbl[i].full;
            @(negedge fe_clk);
            chk($sformatf("tbl%0d_wr", i), 32'(O_fifo_wr), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_cmd", i), 32'(O_fifo_command), 32'(tbl[i].ecmd));
            chk($sformatf("tbl%0d_time", i), 32'(O_fifo_time), 32'(tbl[i].etime));
            chk($sformatf("tbl%0d_count", i), 32'(O_event_count), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_capturing", i), 32'(O_capturing), 32'(tbl[i].cap));
            chk($sformatf("tbl%0d_done", i), 32'(O_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_overflow", i), 32'(O_overflow), 32'(tbl[i].ovf));
            @(posedge fe_clk);
            #1;
        end

        // ---- hand sequences, model-checked every cycle ----
        hard_reset();
        I_max_short_timestamp = 16'd7;
        I_capture_len = 0;

        // Events 3 cycles apart after a TIME entry for the first one.
        wlog.delete();
        step(1, 0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 5; k++) begin
            idle(2);
            step(0, 0, 1, FE_FIFO_CMD_DATA, 0, 0);
        end
        idle(2);
        chk_log("spaced0", 0, FE_FIFO_CMD_TIME, 16'd2);
        chk_log("spaced1", 1, FE_FIFO_CMD_DATA, 16'd0);
        for (int k = 2; k < 6; k++) chk_log($sformatf("spaced%0d", k), k, FE_FIFO_CMD_DATA, 16'd3);
        chk("spaced_count", 32'(s_cnt), 5);

        // Idle 20 then one event.
        step(0, 1, 0, 2'b00, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0);
        wlog.delete();
        idle(20);
        step(0, 0, 1, FE_FIFO_CMD_DATA, 0, 0);
        idle(2);
        chk("single_nwr", 32'(wlog.size()), 2);
        chk_log("single0", 0, FE_FIFO_CMD_TIME, 16'd20);
        chk_log("single1", 1, FE_FIFO_CMD_DATA, 16'd0);

        // Idle 20 then four back-to-back events.
        step(0, 1, 0, 2'b00, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0);
        wlog.delete();
        idle(20);
        repeat (4) step(0, 0, 1, FE_FIFO_CMD_DATA, 0, 0);
        idle(3);
        chk("burst_nwr", 32'(wlog.size()), 5);
        chk_log("burst0", 0, FE_FIFO_CMD_TIME, 16'd20);
        chk_log("burst1", 1, FE_FIFO_CMD_DATA, 16'd0);
        for (int k = 2; k < 5; k++) chk_log($sformatf("burst%0d", k), k, FE_FIFO_CMD_DATA, 16'd1);

        // Length limit 5 against a continuous stream.
        step(0, 1, 0, 2'b00, 0, 0);
        I_capture_len = 24'd5;
        step(1, 0, 0, 2'b00, 0, 0);
        wlog.delete();
        repeat (12) step(0, 0, 1, FE_FIFO_CMD_STAT, 0, 0);
        idle(2);
        n_evw = 0;
        foreach (wlog[k]) if (wlog[k].cmd != FE_FIFO_CMD_TIME) n_evw++;
        chk("limit_event_writes", 32'(n_evw), 5);
        chk("limit_done", 32'(s_done), 1);
        chk("limit_capturing", 32'(s_cap), 0);

        // Overflow on a scheduled write, then re-arm clears it.
        I_capture_len = 0;
        step(1, 0, 0, 2'b00, 0, 0);
        idle(2);
        step(0, 0, 1, FE_FIFO_CMD_DATA, 0, 0);
        step(0, 0, 1, FE_FIFO_CMD_DATA, 1, 0);
        idle(1);
        chk("ovf_flag", 32'(s_ovf), 1);
        chk("ovf_capturing", 32'(s_cap), 0);
        step(1, 0, 0, 2'b00, 0, 0);
        idle(1);
        chk("rearm_overflow", 32'(s_ovf), 0);
        chk("rearm_count", 32'(s_cnt), 0);
        chk("rearm_capturing", 32'(s_cap), 1);

        // Saturated gap, then reset in the middle of a pending write.
        step(0, 1, 0, 2'b00, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0);
        idle(66000);
        wlog.delete();
        step(0, 0, 1, FE_FIFO_CMD_DATA, 0, 0);
        step(0, 0, 1, FE_FIFO_CMD_DATA, 0, 1);
        idle(1);
        chk_log("sat0", 0, FE_FIFO_CMD_TIME, 16'hFFFF);
        chk("rst_wr", 32'(s_wr), 0);
        chk("rst_cmd", 32'(s_cmd), 0);
        chk("rst_time", 32'(s_time), 0);
        chk("rst_capturing", 32'(s_cap), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_overflow", 32'(s_ovf), 0);
        chk("rst_count", 32'(s_cnt), 0);

        // ---- randomized traffic against the model ----
        burst = 0;
        for (int k = 0; k < 3000; k++) begin
            logic a, s, e, f, r;
            logic [1:0] c;
            if ($urandom_range(0, 15) == 0) burst = !burst;
            a = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 119) == 0);
            e = burst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 699) == 0);
            c = ($urandom_range(0, 1) == 0) ? FE_FIFO_CMD_DATA : FE_FIFO_CMD_STAT;
            if (a) I_capture_len = 24'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) I_max_short_timestamp = 16'($urandom_range(1, 6));
            step(a, s, e, c, f, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
